conv_postproc: RTL and testbench

- Downstream stage of the 1-D row convolution engine: captures its 30 signed 18-bit results on the engine's one-cycle done pulse.
- Applies ReLU, 2:1 max pooling, right-shift requantisation and unsigned 8-bit saturation.
- Streams the 15 pooled bytes out over a valid/ready handshake, then reports the row peak value and its index.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_postproc_if.sv | 22 ++
 rtl/pool_quant.sv | 29 ++
 rtl/conv_postproc.sv | 91 +++++++++
 tb/tb_conv_postproc.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the row convolution engine and its
// post-processing stage.
package conv_pkg;

   localparam int N_IN  = 30;
   localparam int IN_W  = 18;
   localparam int OUT_W = 8;
   localparam int SHIFT = 2;
   localparam int N_OUT = N_IN / 2;
   localparam int IDX_W = 4;

   typedef logic signed [IN_W-1:0] elem_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

endpackage

// File: rtl/conv_postproc_if.sv
// Output stream of the post-processing stage: one pooled byte per
// valid/ready transfer, tagged with its index and a last flag.
interface conv_postproc_if;
   import conv_pkg::*;

   logic             valid;
   logic             ready;
   logic [OUT_W-1:0] data;
   logic [IDX_W-1:0] index;
   logic             last;

   modport master (
      output valid, data, index, last,
      input  ready
   );

   modport slave (
      input  valid, data, index, last,
      output ready
   );

endinterface

// File: rtl/pool_quant.sv
// One pooled output element: ReLU on both inputs, max of the pair,
// right shift, then clamp to the unsigned output range.
module pool_quant
   import conv_pkg::*;
(
   input  elem_t            a,
   input  elem_t            b,
   output logic [OUT_W-1:0] q
);

   typedef logic [IN_W-2:0] mag_t;

   localparam mag_t SAT = mag_t'((1 << OUT_W) - 1);

   mag_t ra;
   mag_t rb;
   mag_t r;
   mag_t s;

   // relu, pair max, shift and saturate on the full-width value
   always_comb begin
      ra = a[IN_W-1] ? '0 : a[IN_W-2:0];
      rb = b[IN_W-1] ? '0 : b[IN_W-2:0];
      r  = (ra > rb) ? ra : rb;
      s  = r >> SHIFT;
      q  = (s > SAT) ? '1 : s[OUT_W-1:0];
   end

endmodule

// File: rtl/conv_postproc.sv
// Captures a convolution row, streams 15 pooled/requantised bytes and
// reports the row peak and its first index.
module conv_postproc
   import conv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  elem_t            in_data [N_IN],
   output logic             busy,
   conv_postproc_if.master  os,
   output logic             peak_valid,
   output logic [OUT_W-1:0] peak_value,
   output logic [IDX_W-1:0] peak_index,
   output logic             overrun
);

   state_t           state;
   state_t           state_nx;
   elem_t            bank [N_IN];
   logic [IDX_W-1:0] cnt;
   logic [IDX_W:0]   ia;
   logic [IDX_W:0]   ib;
   logic [OUT_W-1:0] q;
   logic             acc;
   logic             xfer;
   logic             last_el;

   assign ia      = {cnt, 1'b0};
   assign ib      = {cnt, 1'b1};
   assign acc     = in_valid && (state == S_IDLE);
   assign xfer    = os.valid && os.ready;
   assign last_el = (cnt == IDX_W'(N_OUT - 1));

   pool_quant u_pq (
      .a (bank[ia]),
      .b (bank[ib]),
      .q (q)
   );

   assign os.valid   = (state == S_RUN);
   assign os.data    = q;
   assign os.index   = cnt;
   assign os.last    = os.valid && last_el;
   assign busy       = (state != S_IDLE);
   assign peak_valid = (state == S_DONE);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // next state: accept, stream until last transfer, one-cycle report
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (in_valid) state_nx = S_RUN;
         S_RUN:   if (xfer && last_el) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // capture bank, element counter, running peak and sticky overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         bank       <= '{default: '0};
         cnt        <= '0;
         peak_value <= '0;
         peak_index <= '0;
         overrun    <= 1'b0;
      end else begin
         if (acc) begin
            bank       <= in_data;
            cnt        <= '0;
            peak_value <= '0;
            peak_index <= '0;
         end
         if (in_valid && state != S_IDLE) overrun <= 1'b1;
         if (xfer) begin
            if (!last_el) cnt <= cnt + 1'b1;
            if (q > peak_value) begin
               peak_value <= q;
               peak_index <= cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_postproc.sv
// Directed and randomised rows against a pair-wise reference model of
// the pooled byte stream, peak report and overrun flag.
module tb_conv_postproc;
   import conv_pkg::*;

   typedef int row_t [N_IN];

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   elem_t            in_data [N_IN];
   logic             busy;
   logic             peak_valid;
   logic [OUT_W-1:0] peak_value;
   logic [IDX_W-1:0] peak_index;
   logic             overrun;

   int checks = 0;
   int errors = 0;

   conv_postproc_if os ();

   conv_postproc dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .busy       (busy),
      .os         (os),
      .peak_valid (peak_valid),
      .peak_value (peak_value),
      .peak_index (peak_index),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_el(input int a, input int b);
      int r;
      r = 0;
      if (a > r) r = a;
      if (b > r) r = b;
      r = r / (1 << SHIFT);
      return (r > 255) ? 255 : r;
   endfunction

   function automatic int rnd(input int lo, input int hi);
      return lo + int'($urandom_range(hi - lo));
   endfunction

   task automatic drive_row(input row_t r);
      for (int i = 0; i < N_IN; i++) in_data[i] = elem_t'(r[i]);
   endtask

   task automatic rand_row(output row_t r);
      for (int i = 0; i < N_IN; i++)
         r[i] = ($urandom_range(3) == 0) ? rnd(-131072, 131071)
                                         : rnd(-1500, 1500);
   endtask

   task automatic run_row(input string nm, input row_t r,
                          input bit [14:0] stall, input int inj,
                          input int rst_at);
      int   e [N_OUT];
      int   pv;
      int   pi;
      int   k;
      int   held;
      int   cyc;
      int   seen;
      bit   injected;
      row_t alt;
      pv = 0;
      pi = 0;
      for (int j = 0; j < N_OUT; j++) begin
         e[j] = ref_el(r[2*j], r[2*j+1]);
         if (e[j] > pv) begin
            pv = e[j];
            pi = j;
         end
      end
      drive_row(r);
      in_valid = 1'b1;
      os.ready = 1'b1;
      @(negedge clk);
      k = 0;
      held = 0;
      cyc = 0;
      injected = 1'b0;
      while (k < N_OUT && cyc < 100) begin
         cyc++;
         in_valid = 1'b0;
         if (k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk({nm, " rst valid"}, os.valid, 0);
            chk({nm, " rst busy"}, busy, 0);
            chk({nm, " rst overrun"}, overrun, 0);
            seen = 0;
            repeat (20) begin
               if (peak_valid) seen++;
               @(negedge clk);
            end
            chk({nm, " rst no peak"}, seen, 0);
            return;
         end
         if (k == inj && !injected) begin
            for (int i = 0; i < N_IN; i++) alt[i] = r[i] + 4000;
            drive_row(alt);
            in_valid = 1'b1;
            injected = 1'b1;
         end
         os.ready = !(stall[k] && held < 3);
         if (!os.ready) held++;
         chk({nm, " valid"}, os.valid, 1);
         chk({nm, " busy"}, busy, 1);
         chk({nm, " index"}, os.index, k);
         chk({nm, " data"}, os.data, e[k]);
         chk({nm, " last"}, os.last, (k == N_OUT - 1));
         if (os.ready) begin
            k++;
            held = 0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      os.ready = 1'b1;
      chk({nm, " count"}, k, N_OUT);
      chk({nm, " peak_valid"}, peak_valid, 1);
      chk({nm, " peak_value"}, peak_value, pv);
      chk({nm, " peak_index"}, peak_index, pi);
      chk({nm, " done valid"}, os.valid, 0);
      @(negedge clk);
      chk({nm, " peak_valid drop"}, peak_valid, 0);
      chk({nm, " idle busy"}, busy, 0);
      chk({nm, " held peak"}, peak_value, pv);
   endtask

   initial begin
      row_t r;
      os.ready = 1'b1;
      for (int i = 0; i < N_IN; i++) in_data[i] = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset valid", os.valid, 0);
      chk("reset last", os.last, 0);
      chk("reset data", os.data, 0);
      chk("reset index", os.index, 0);
      chk("reset peak_valid", peak_valid, 0);
      chk("reset peak_value", peak_value, 0);
      chk("reset peak_index", peak_index, 0);
      chk("reset overrun", overrun, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < N_IN; i++) r[i] = 0;
      run_row("zero", r, '0, -1, -1);

      rand_row(r);
      r[0]  = 100;    r[1]  = -50;
      r[2]  = -7;     r[3]  = -300;
      r[4]  = 1020;   r[5]  = 3;
      r[6]  = 1024;   r[7]  = 0;
      r[8]  = 131071; r[9]  = -131072;
      r[10] = 5;      r[11] = 6;
      run_row("corner", r, '0, -1, -1);

      for (int j = 0; j < N_OUT; j++) begin
         r[2*j]   = -j;
         r[2*j+1] = 4 * j;
      end
      run_row("stall", r, 15'b100_0000_1000_0001, -1, -1);

      for (int i = 0; i < N_IN; i++) r[i] = rnd(-2000, 799);
      r[6]  = 800;  r[7]  = -1;
      r[18] = -5;   r[19] = 803;
      run_row("tie", r, '0, -1, -1);

      rand_row(r);
      run_row("overrun", r, '0, 5, -1);
      chk("overrun set", overrun, 1);
      rand_row(r);
      run_row("after_ovr", r, 15'b000_0010_0000_0100, -1, -1);
      chk("overrun sticky", overrun, 1);

      rand_row(r);
      run_row("midrst", r, '0, -1, 8);
      rand_row(r);
      run_row("restart", r, '0, -1, -1);

      for (int n = 0; n < 3; n++) begin
         rand_row(r);
         run_row("random", r, 15'($urandom), -1, -1);
      end
      chk("final overrun", overrun, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
